// File: rtl/aes_ahb_slave_regs_if.sv
// AHB-Lite signal bundle between a bus master and the AES register-file responder.
interface aes_ahb_slave_regs_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/aes_ahb_slave_regs.sv
// AHB-Lite register file for the AES-128 core: CTRL/STAT/KEY/PT/CT registers,
// launch control (START+PT3 or BIST enable) and ciphertext capture.
module aes_ahb_slave_regs #(
    parameter int unsigned ADDR_DEC_W = 6,
    parameter bit          ERR_EN     = 1'b1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    aes_ahb_slave_regs_if.slave  bus,
    output logic [127:0]         aes_key,
    output logic [127:0]         aes_pt,
    output logic                 aes_start,
    output logic                 bist_en,
    input  logic                 core_busy,
    input  logic                 core_done,
    input  logic [127:0]         core_ct
);

    typedef enum logic [1:0] {PH_IDLE, PH_DATA, PH_ERR1, PH_ERR2} phase_t;

    phase_t      phase;
    logic [3:0]  dph_idx;
    logic        dph_write;
    logic        hreadyout_q;
    logic        hresp_q;
    logic [31:0] hrdata_q;
    logic [31:0] rd_mux;

    logic [31:0] key_q [4];
    logic [31:0] pt_q  [4];
    logic [31:0] ct_q  [4];
    logic        armed;
    logic        done;

    // Address-phase decode
    logic [ADDR_DEC_W-1:0] a_off;
    logic [3:0]            a_idx;
    logic                  a_mapped;
    logic                  a_ro;
    logic                  a_err;
    logic                  accept;
    logic                  wr_en;
    logic                  rd_en;
    logic                  unused_bus;

    assign a_off    = bus.HADDR[ADDR_DEC_W-1:0];
    assign a_idx    = a_off[5:2];
    assign a_mapped = ((a_off >> 6) == '0) && (a_off[1:0] == 2'b00) && (a_idx != 4'h3);
    assign a_ro     = (a_idx == 4'h2) || (a_idx[3:2] == 2'b11);
    assign a_err    = ERR_EN && (!a_mapped || (bus.HSIZE != 3'b010) || (bus.HWRITE && a_ro));
    assign accept   = bus.HSEL && bus.HREADY && bus.HTRANS[1] && (phase != PH_ERR1);

    assign unused_bus = ^{bus.HBURST, bus.HADDR[31:ADDR_DEC_W]};

    assign wr_en = (phase == PH_DATA) && dph_write;
    assign rd_en = (phase == PH_DATA) && !dph_write;

    // Bus phase FSM; erroring transfers never reach PH_DATA, so they touch no register
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            phase       <= PH_IDLE;
            dph_idx     <= '0;
            dph_write   <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else if (accept) begin
            dph_idx   <= a_idx;
            dph_write <= bus.HWRITE;
            if (a_err) begin
                phase       <= PH_ERR1;
                hreadyout_q <= 1'b0;
                hresp_q     <= 1'b1;
            end else begin
                phase       <= PH_DATA;
                hreadyout_q <= 1'b1;
                hresp_q     <= 1'b0;
            end
        end else if (phase == PH_ERR1) begin
            phase       <= PH_ERR2;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b1;
        end else begin
            phase       <= PH_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (dph_idx)
            4'h1:                   rd_mux = {31'd0, bist_en};
            4'h2:                   rd_mux = {29'd0, armed, core_busy, done};
            4'h4, 4'h5, 4'h6, 4'h7: rd_mux = key_q[dph_idx[1:0]];
            4'h8, 4'h9, 4'hA, 4'hB: rd_mux = pt_q[dph_idx[1:0]];
            4'hC, 4'hD, 4'hE, 4'hF: rd_mux = ct_q[dph_idx[1:0]];
            default:                rd_mux = '0;
        endcase
    end

    assign bus.HRDATA    = rd_en ? rd_mux : hrdata_q;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;

    // Clears from a START/BIST write are placed after the core_done set so they win
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            key_q     <= '{default: '0};
            pt_q      <= '{default: '0};
            ct_q      <= '{default: '0};
            armed     <= 1'b0;
            done      <= 1'b0;
            bist_en   <= 1'b0;
            aes_start <= 1'b0;
            hrdata_q  <= '0;
        end else begin
            aes_start <= 1'b0;
            if (rd_en) begin
                hrdata_q <= rd_mux;
            end
            if (core_done) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    ct_q[i] <= core_ct[32*i +: 32];
                end
                done <= 1'b1;
            end
            if (wr_en) begin
                case (dph_idx)
                    4'h0: begin
                        if (bus.HWDATA[0]) begin
                            armed <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                    4'h1: begin
                        bist_en <= bus.HWDATA[0];
                        if (bus.HWDATA[0] && !bist_en) begin
                            aes_start <= 1'b1;
                            done      <= 1'b0;
                            armed     <= 1'b0;
                        end
                    end
                    4'h4, 4'h5, 4'h6, 4'h7: begin
                        if (!core_busy) key_q[dph_idx[1:0]] <= bus.HWDATA;
                    end
                    4'h8, 4'h9, 4'hA, 4'hB: begin
                        if (!core_busy) begin
                            pt_q[dph_idx[1:0]] <= bus.HWDATA;
                            if ((dph_idx == 4'hB) && armed && !bist_en) begin
                                aes_start <= 1'b1;
                                armed     <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign aes_key = {key_q[3], key_q[2], key_q[1], key_q[0]};
    assign aes_pt  = {pt_q[3], pt_q[2], pt_q[1], pt_q[0]};

endmodule

// File: tb/tb_aes_ahb_slave_regs.sv
// Scoreboard bench for aes_ahb_slave_regs: the driver queues expected bus responses,
// a negedge monitor pops and checks them as each data phase completes.
module tb_aes_ahb_slave_regs;

    localparam logic [2:0] SZ_WORD = 3'b010;
    localparam logic [2:0] SZ_BYTE = 3'b000;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b1;
    always #5 HCLK = ~HCLK;

    aes_ahb_slave_regs_if bus ();
    assign bus.HREADY = bus.HREADYOUT;

    logic [127:0] aes_key, aes_pt, core_ct;
    logic         aes_start, bist_en, core_busy, core_done;

    aes_ahb_slave_regs #(.ADDR_DEC_W(7), .ERR_EN(1'b1)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .bus       (bus),
        .aes_key   (aes_key),
        .aes_pt    (aes_pt),
        .aes_start (aes_start),
        .bist_en   (bist_en),
        .core_busy (core_busy),
        .core_done (core_done),
        .core_ct   (core_ct)
    );

    typedef struct {
        string       name;
        bit          rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   start_cnt = 0;

    initial forever begin
        @(negedge HCLK);
        if (aes_start === 1'b1) start_cnt++;
    end

    // Monitor: completes a data phase on the negedge where HREADYOUT is high
    initial begin : monitor
        bit   act;
        int   waits;
        bit   bad;
        exp_t e;
        act = 0; waits = 0; bad = 0;
        forever begin
            @(negedge HCLK);
            if (act) begin
                if (bus.HREADYOUT !== 1'b1) begin
                    waits++;
                    if (bus.HRESP !== 1'b1) bad = 1;
                end else begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_xfer actual=resp%0b required=no_transfer", bus.HRESP);
                    end else begin
                        e = sb.pop_front();
                        if ((bus.HRESP !== e.err) || (waits != (e.err ? 1 : 0)) || bad ||
                            (e.rd && !e.err && (bus.HRDATA !== e.data))) begin
                            failures++;
                            $display("FAIL %s actual=resp%0b/waits%0d/rdata%h required=resp%0b/waits%0d/rdata%h",
                                     e.name, bus.HRESP, waits, bus.HRDATA, e.err, e.err ? 1 : 0, e.data);
                        end
                    end
                    act = 0; waits = 0; bad = 0;
                end
            end
            if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) act = 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic xfer(input string name, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] size, input logic [31:0] exp_rd, input bit exp_err);
        exp_t e;
        int   n;
        bus.HSEL = 1'b1; bus.HADDR = addr; bus.HTRANS = 2'b10; bus.HWRITE = wr; bus.HSIZE = size;
        e.name = name; e.rd = !wr; e.data = exp_rd; e.err = exp_err;
        sb.push_back(e);
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = wdata;
        n = 0;
        while ((bus.HREADYOUT !== 1'b1) && (n < 8)) begin
            @(posedge HCLK); #1;
            n++;
        end
        if (n >= 8) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=HREADYOUT_low required=HREADYOUT_high", name);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data);
        xfer(name, 1'b1, addr, data, SZ_WORD, 32'h0, 1'b0);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        xfer(name, 1'b0, addr, 32'h0, SZ_WORD, exp, 1'b0);
    endtask

    task automatic pulse_done(input logic [127:0] ct);
        core_ct = ct; core_done = 1'b1;
        @(posedge HCLK); #1;
        core_done = 1'b0;
    endtask

    // Write immediately followed by a read of the same register, overlapping phases
    task automatic b2b_wr_rd(input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        bus.HSEL = 1'b1; bus.HADDR = addr; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HSIZE = SZ_WORD;
        e.name = "b2b_wr"; e.rd = 0; e.data = 32'h0; e.err = 0;
        sb.push_back(e);
        @(posedge HCLK); #1;
        bus.HWDATA = data; bus.HWRITE = 1'b0;
        e.name = "b2b_rd"; e.rd = 1; e.data = data; e.err = 0;
        sb.push_back(e);
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        @(posedge HCLK); #1;
    endtask

    logic [31:0] map_addr [15] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14, 32'h18, 32'h1C,
                                   32'h20, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C};
    logic [31:0] key_w [4] = '{32'h0C0D0E0F, 32'h08090A0B, 32'h04050607, 32'h00010203};
    logic [31:0] pt_w  [4] = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};

    initial begin
        bus.HSEL = 0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 0;
        bus.HSIZE = SZ_WORD; bus.HBURST = 3'b000; bus.HWDATA = '0;
        core_busy = 0; core_done = 0; core_ct = '0;

        // Reset
        repeat (10) @(posedge HCLK);
        #1;
        chk("rst_hreadyout", bus.HREADYOUT, 1'b1);
        chk("rst_hresp", bus.HRESP, 1'b0);
        chk("rst_hrdata", bus.HRDATA, 32'h0);
        chk("rst_outputs", {aes_start, bist_en}, 2'b00);
        chk("rst_key_pt", aes_key | aes_pt, 128'h0);
        @(negedge HCLK) HRESETn = 1'b0;
        @(posedge HCLK); #1;
        for (int i = 0; i < 15; i++) rd($sformatf("rst_rd_%h", map_addr[i]), map_addr[i], 32'h0);

        // Key round trip
        for (int i = 0; i < 4; i++) wr("key_wr", 32'h10 + 4 * i, key_w[i]);
        for (int i = 0; i < 4; i++) rd($sformatf("key_rd%0d", i), 32'h10 + 4 * i, key_w[i]);
        chk("aes_key", aes_key, 128'h000102030405060708090A0B0C0D0E0F);

        // Normal launch
        wr("start", 32'h00, 32'h1);
        rd("stat_armed", 32'h08, 32'h4);
        for (int i = 0; i < 4; i++) wr("key_wr2", 32'h10 + 4 * i, key_w[i]);
        for (int i = 0; i < 3; i++) wr("pt_wr", 32'h20 + 4 * i, pt_w[i]);
        chk("no_start_before_pt3", start_cnt, 0);
        wr("pt3_wr", 32'h2C, pt_w[3]);
        chk("launch_pulse", aes_start, 1'b1);
        chk("aes_pt", aes_pt, 128'h00112233445566778899AABBCCDDEEFF);
        core_busy = 1'b1;
        rd("stat_busy", 32'h08, 32'h2);
        chk("launch_count", start_cnt, 1);
        wr("pt0_busy", 32'h20, 32'hFFFFFFFF);
        rd("pt0_unchanged", 32'h20, 32'hCCDDEEFF);
        chk("aes_pt_stable", aes_pt, 128'h00112233445566778899AABBCCDDEEFF);
        core_busy = 1'b0;
        pulse_done(128'h69C4E0D86A7B0430D8CDB78070B4C55A);
        rd("stat_done", 32'h08, 32'h1);
        rd("ct0", 32'h30, 32'h70B4C55A);
        rd("ct1", 32'h34, 32'hD8CDB780);
        rd("ct2", 32'h38, 32'h6A7B0430);
        rd("ct3", 32'h3C, 32'h69C4E0D8);

        // BIST
        wr("bist_on", 32'h04, 32'h1);
        chk("bist_pulse", aes_start, 1'b1);
        chk("bist_en", bist_en, 1'b1);
        rd("stat_bist_clr", 32'h08, 32'h0);
        chk("bist_count", start_cnt, 2);
        rd("ctrl1_rd", 32'h04, 32'h1);
        wr("start_in_bist", 32'h00, 32'h1);
        wr("pt3_in_bist", 32'h2C, 32'h00112233);
        rd("stat_bist_armed", 32'h08, 32'h4);
        chk("bist_no_pt3_launch", start_cnt, 2);
        pulse_done(128'hCAFEF00D0BADC0DE123456789ABCDEF0);
        rd("stat_bist_done", 32'h08, 32'h5);
        rd("bist_ct0", 32'h30, 32'h9ABCDEF0);
        wr("bist_off", 32'h04, 32'h0);
        chk("bist_off_en", bist_en, 1'b0);
        chk("bist_off_nopulse", aes_start, 1'b0);
        wr("pt3_relaunch", 32'h2C, 32'h00112233);
        chk("relaunch_pulse", aes_start, 1'b1);
        rd("stat_relaunch", 32'h08, 32'h1);
        chk("relaunch_count", start_cnt, 3);

        // ERROR responses
        xfer("err_wr_stat", 1'b1, 32'h08, 32'hFFFFFFFF, SZ_WORD, 32'h0, 1'b1);
        rd("stat_after_err", 32'h08, 32'h1);
        xfer("err_rd_40", 1'b0, 32'h40, 32'h0, SZ_WORD, 32'h0, 1'b1);
        xfer("err_byte", 1'b1, 32'h10, 32'hFFFFFFFF, SZ_BYTE, 32'h0, 1'b1);
        rd("key0_after_err", 32'h10, 32'h0C0D0E0F);
        xfer("err_wr_ct0", 1'b1, 32'h30, 32'hFFFFFFFF, SZ_WORD, 32'h0, 1'b1);
        rd("ct0_after_err", 32'h30, 32'h9ABCDEF0);
        xfer("err_rd_0c", 1'b0, 32'h0C, 32'h0, SZ_WORD, 32'h0, 1'b1);

        // Back-to-back write then read of the same register
        b2b_wr_rd(32'h14, 32'hA5A55A5A);
        chk("b2b_aes_key", aes_key[63:32], 32'hA5A55A5A);

        // core_done colliding with a START write
        fork
            wr("start_collide", 32'h00, 32'h1);
            begin
                @(posedge HCLK); #1;
                core_ct = 128'h11111111222222223333333344444444;
                core_done = 1'b1;
                @(posedge HCLK); #1;
                core_done = 1'b0;
            end
        join
        rd("stat_collide", 32'h08, 32'h4);
        rd("ct0_collide", 32'h30, 32'h44444444);
        rd("ct3_collide", 32'h3C, 32'h11111111);
        chk("final_count", start_cnt, 3);

        repeat (2) @(posedge HCLK);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_ahb_slave_regs.md
Name: aes_ahb_slave_regs

Overview:
AHB-Lite responder and register file in front of the 8-bit-datapath AES-128 core. It decodes single 32-bit NONSEQ transfers into the CTRL, STAT, KEY, PT and CT registers. It drives the key, plaintext, start and BIST controls to the core, and captures the core's ciphertext/MISR result and completion status. Both bus masters and the system testbench use it as the only software-visible path to the core.

Parameters:
ADDR_DEC_W, 6, number of low HADDR bits decoded; upper bits are ignored and HSEL qualifies the transfer.
ERR_EN, 1, 1 = unmapped, illegal-size and read-only-write accesses get a two-cycle ERROR response; 0 = always OKAY.

Ports:
HCLK  in  1  bus clock, rising edge.
HRESETn  in  1  asynchronous reset, active-high.
HSEL  in  1  slave select.
HADDR  in  32  byte address.
HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) are acted on.
HWRITE  in  1  1 = write.
HSIZE  in  3  must be 3'b010 (word).
HBURST  in  3  ignored; every beat is decoded individually.
HWDATA  in  32  write data, valid in the data phase.
HREADY  in  1  bus ready; the address phase is accepted only when this is 1.
HRDATA  out  32  read data.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0 = OKAY, 1 = ERROR.
aes_key  out  128  {KEY3,KEY2,KEY1,KEY0}.
aes_pt  out  128  {PT3,PT2,PT1,PT0}.
aes_start  out  1  one-cycle launch pulse to the core.
bist_en  out  1  CTRL1[0].
core_busy  in  1  core is running.
core_done  in  1  one-cycle completion pulse.
core_ct  in  128  ciphertext, or MISR signature in BIST mode.

Behaviour:
- Reset values: all registers 0. HRDATA=0, HREADYOUT=1, HRESP=0, aes_start=0, bist_en=0, aes_key=0, aes_pt=0.
- Address phase accept: HSEL & HREADY & HTRANS[1]. Address, write flag and size are latched. The data phase is the following cycle.
- Register map (offsets):
  - 0x00 CTRL0: bit0 START, write-only pulse; reads 0.
  - 0x04 CTRL1: bit0 BIST_EN, read/write.
  - 0x08 STAT0: bit0 DONE (sticky), bit1 BUSY (=core_busy), bit2 ARMED; read-only.
  - 0x10–0x1C KEY0–3, read/write.
  - 0x20–0x2C PT0–3, read/write.
  - 0x30–0x3C CT0–3, read-only. CT0 = ct_reg[31:0].
- Writes take effect at the end of the data phase using HWDATA. Zero wait states.
- Reads: HRDATA is combinational from the latched address during the data phase. Afterwards HRDATA holds the last read value until the next accepted read.
- START write: sets ARMED, clears DONE.
- PT3 write while ARMED: aes_start pulses high the cycle after the PT3 data phase; ARMED clears.
- START write while ARMED and PT3 already written: no immediate launch; a new PT3 write is still required.
- KEY/PT writes while core_busy=1 are ignored (OKAY response). aes_key/aes_pt stay stable for the whole run.
- BIST_EN 0->1 write: aes_start pulses the next cycle, DONE clears, ARMED clears.
- BIST_EN 1->0 write: no pulse.
- While bist_en=1, the PT3 launch path is disabled.
- core_done: ct_reg <= core_ct and DONE <= 1 on the same edge.
- core_done in the same cycle as a START write: DONE ends at 0 (the clear wins), but ct_reg is still captured.
- ERROR (ERR_EN=1) is raised for: unmapped offset, HSIZE != word, or write to STAT0/CT0–3.
  - Data-phase cycle 1: HREADYOUT=0, HRESP=1.
  - Data-phase cycle 2: HREADYOUT=1, HRESP=1.
  - No register is modified.
  - An address phase presented during cycle 1 is not accepted (HREADY=0).
- Back-to-back transfers: an address phase overlapping a write data phase is accepted. A read of the register being written in the previous beat returns the new value.
- Reset asserted mid-transfer: all state clears asynchronously; any pending aes_start is dropped.

Test Plan:
- Reset: assert HRESETn=1 for 10 cycles then release -> read every mapped register returns 0x00000000; HREADYOUT=1, HRESP=0 throughout.
- Register round-trip: write KEY0–3 = 0x0C0D0E0F, 0x08090A0B, 0x04050607, 0x00010203 -> readback matches, aes_key=128'h000102030405060708090A0B0C0D0E0F.
- Normal launch: write START, then KEY0–3 and PT0–3 (PT = 128'h00112233445566778899AABBCCDDEEFF) -> exactly one aes_start pulse, the cycle after the PT3 data phase. Model core_done with core_ct = 128'h69C4E0D86A7B0430D8CDB78070B4C55A -> STAT0=0x1, CT0=0x70B4C55A, CT3=0x69C4E0D8.
- BIST: write CTRL1=1 -> aes_start pulses once, bist_en=1, STAT0.DONE=0. A subsequent PT3 write produces no pulse. core_done -> DONE=1.
- ERROR cases: write 0x08, read 0x40, HSIZE=byte -> each gives the two-cycle ERROR sequence; register contents are unchanged.
- Busy and collision: with core_busy=1, write PT0=0xFFFFFFFF -> PT0 unchanged. Fire core_done and a START write in the same cycle -> DONE=0, ct_reg updated.
